// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath widths and an id-width helper.
package alu_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'b00010;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 5'b00100;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 5'b00101;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'b01001;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'b01010;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 5'b01011;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 5'b01110;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 5'b01111;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 5'b10000;
  localparam logic [ALU_OP_W-1:0] ALU_PASS = 5'b11110;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational 32-bit ALU; unknown opcodes yield zero.
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]     src0,
  input  logic [XLEN-1:0]     src1,
  input  logic [ALU_OP_W-1:0] op,
  output logic [XLEN-1:0]     result
);

  logic [4:0] shamt;
  assign shamt = src1[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = src0 + src1;
      ALU_SUB:  result = src0 - src1;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(src0) < $signed(src1))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (src0 < src1)};
      ALU_AND:  result = src0 & src1;
      ALU_OR:   result = src0 | src1;
      ALU_XOR:  result = src0 ^ src1;
      ALU_SLL:  result = src0 << shamt;
      ALU_SRL:  result = src0 >> shamt;
      ALU_SRA:  result = $unsigned($signed(src0) >>> shamt);
      ALU_PASS: result = src1;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// One-hot request arbiter: round-robin from rr_ptr by default,
// lowest-index fixed priority when ALU_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int ID_W = id_width(NUM_REQ);

`ifdef ALU_ARB_FIXED_PRIO_EN

  logic found;
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, advance};

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

`else

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_idx;
  logic            found;
  int              idx;

  // Search starts at rr_ptr and wraps; first asserted request wins.
  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx] && !found) begin
        grant[idx] = 1'b1;
        win_idx    = idx[ID_W-1:0];
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
    end
  end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared ALU with a one-entry response register.
// Macro ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4,
  localparam int ID_W   = id_width(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*XLEN-1:0]     req_src0,
  input  logic [NUM_REQ*XLEN-1:0]     req_src1,
  input  logic [NUM_REQ*ALU_OP_W-1:0] req_op,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [XLEN-1:0]             rsp_data,
  output logic [ID_W-1:0]             rsp_id,
  output logic [TAG_W-1:0]            rsp_tag
);

  logic [NUM_REQ-1:0]  grant;
  logic                can_accept;
  logic                accept;
  logic [XLEN-1:0]     sel_src0;
  logic [XLEN-1:0]     sel_src1;
  logic [ALU_OP_W-1:0] sel_op;
  logic [TAG_W-1:0]    sel_tag;
  logic [ID_W-1:0]     sel_id;
  logic [XLEN-1:0]     alu_result;

  // rst_n gating keeps req_ready low for the whole reset period.
  assign can_accept = (!rsp_valid | rsp_ready) & rst_n;
  assign req_ready  = grant & {NUM_REQ{can_accept}};
  assign accept     = |req_ready;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    sel_src0 = '0;
    sel_src1 = '0;
    sel_op   = '0;
    sel_tag  = '0;
    sel_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_src0 = req_src0[XLEN*i +: XLEN];
        sel_src1 = req_src1[XLEN*i +: XLEN];
        sel_op   = req_op[ALU_OP_W*i +: ALU_OP_W];
        sel_tag  = req_tag[TAG_W*i +: TAG_W];
        sel_id   = ID_W'(i);
      end
    end
  end

  alu u_alu (
    .src0   (sel_src0),
    .src1   (sel_src1),
    .op     (sel_op),
    .result (alu_result)
  );

  // Response register: a new accept overwrites, a bare drain clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_tag   <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_result;
      rsp_id    <= sel_id;
      rsp_tag   <= sel_tag;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `ALU` between `NUM_REQ` requesters (e.g. integer pipe, address generation, CSR update path) using a per-requester valid/ready handshake. Each cycle it picks one request, drives it into the ALU and captures the result in a one-entry output register. The response carries the requester index and a caller tag. It sits between the issue logic and the shared execute resource, with one accept per cycle at full throughput.

## Interface
- `NUM_REQ`, 2: number of requesters, legal 2..8.
- `TAG_W`, 4: width of the opaque per-request tag, legal 1..16.
- `ID_W`, derived: max(1, $clog2(NUM_REQ)). Localparam, not overridable.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: request i is presented.
- `req_ready` out NUM_REQ: request i is accepted this cycle.
- `req_src0` in NUM_REQ*32: operand 0, slice i at [32*i +: 32].
- `req_src1` in NUM_REQ*32: operand 1. Shift ops use only bits [4:0].
- `req_op` in NUM_REQ*5: ALU opcode, slice [5*i +: 5].
- `req_tag` in NUM_REQ*TAG_W: returned unchanged with the result.
- `rsp_valid` out 1: response register holds a result.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out 32: ALU result.
- `rsp_id` out ID_W: index of the originating requester.
- `rsp_tag` out TAG_W: tag of the originating request.

## Operation
- **Opcodes**:
  - ADD 00000, SUB 00010, SLT 00100 (signed), SLTU 00101.
  - AND 01001, OR 01010, XOR 01011.
  - SLL 01110, SRL 01111, SRA 10000 (arithmetic).
  - PASS 11110 returns src1.
  - Any other code yields 0 but still produces a normal response.
- **Accept condition**: `can_accept = !rsp_valid | rsp_ready`.
  - `req_ready[i] = grant[i] & can_accept`.
  - At most one bit of `req_ready` is high per cycle.
- **Grant**: one-hot choice among asserted `req_valid`, computed combinationally.
  - Round-robin search starts at pointer `rr_ptr`.
  - On a handshake with winner w, `rr_ptr` becomes w+1, wrapping from NUM_REQ-1 to 0.
  - `rr_ptr` does not move without a handshake.
- **Requester rules**:
  - `req_valid` must not depend on `req_ready`.
  - Once raised, valid and payload are held until the handshake. The bench flags violations.
- **Capture**: on a handshake, the register loads ALU(src0, src1, op) of the winner, plus id and tag, and `rsp_valid` is set.
- **Response drain**: if `rsp_valid & rsp_ready` occur with no new handshake, `rsp_valid` clears.
- **Stall**: while `rsp_valid & !rsp_ready`, `rsp_data`, `rsp_id` and `rsp_tag` stay bit-stable and all `req_ready` are 0.
- **Simultaneous drain and accept**: the new result replaces the old one in the same edge, so `rsp_valid` stays 1.
- **Fairness**: a continuously valid requester is granted within NUM_REQ handshakes.
- **Reset**: asserting `rst_n`=0 at any time, including mid-stall, discards the pending response. The reset state is:
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_tag`=0, `rr_ptr`=0.
  - `req_ready` is 0 while in reset.

## Timing
- Latency is 1 cycle: a handshake at edge N gives `rsp_valid`=1 after edge N, with data valid in that cycle.
- Throughput is 1 result per cycle while `rsp_ready`=1.
- `req_ready` is combinational from `req_valid`, `rsp_valid` and `rsp_ready`. There is no path from `req_src*`/`req_op` to `req_ready`.
- The ALU sits between the request mux and the response register. The critical path is mux → 32-bit add/compare/shift → register.

## Configuration
- Macro `ALU_ARB_FIXED_PRIO_EN`:
  - **Defined**: fixed priority, where the lowest asserted index always wins. `rr_ptr` is not implemented and the fairness guarantee is void.
  - **Undefined (default)**: round-robin as described in Operation.

## Structure
- Package `alu_pkg` holds:
  - the opcode localparams: ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASS;
  - ALU_OP_W=5 and XLEN=32.
  - The existing ALU and this block both use this package.
- Sub-module `rr_arbiter` (NUM_REQ):
  - Inputs: `req` vector, `advance`.
  - Output: one-hot `grant`.
  - Holds `rr_ptr`, and contains the fixed-priority variant under the macro.
- `alu_arbiter` instantiates `rr_arbiter` and one `ALU`, and holds the response register.

## Test plan
- **Single request**: req0 ADD 5+7, tag 3, `rsp_ready`=1 → next cycle `rsp_valid`=1, data 12, id 0, tag 3. Idle after that → `rsp_valid`=0.
- **Round-robin**: NUM_REQ=2, both valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,0,1. With `ALU_ARB_FIXED_PRIO_EN` → 0,0,0,0.
- **Backpressure**: response pending and `rsp_ready`=0 for 3 cycles → `req_ready`=0 and `rsp_data` stable. On `rsp_ready`=1 with req1 valid → drain and accept in the same cycle, `rsp_valid` stays 1, new id 1.
- **Arithmetic corners**:
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SLT 0xFFFFFFFF,1 → 1.
  - SLTU 0xFFFFFFFF,1 → 0.
  - SLL by src1=0x21 → shift by 1.
  - op 11111 → 0 with a normal response.
- **Pointer wrap**: NUM_REQ=3, only req2 valid and accepted → `rr_ptr`=0. Then req0 and req1 valid → req0 is granted first, then req1.
- **Reset mid-stall**: `rsp_valid`=1 with `rsp_ready`=0, then `rst_n` low mid-cycle → `rsp_valid`=0 immediately, all outputs 0. After release with all valid → first grant to req0.
